// File: rtl/vx_tensor_smem_arbiter.sv
// vx_tensor_smem_arbiter
// Shares one shared-memory bank port between the tensor core's two operand
// fetch streams (A and B). Requests are arbitrated round-robin, limited to
// MAX_OUTSTANDING in flight per source, and registered in a one-entry stage
// before reaching the smem port. Each smem request carries {src, tag}, where
// src is 0 for A and 1 for B. Responses are routed back to A or B
// combinationally, using the echoed src bit.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   a_req_* / b_req_*          source request handshake, addr, tag
//   a_rsp_* / b_rsp_*          source response handshake, tag, data
//   mem_req_*                  smem request (registered stage), addr, {src,tag}
//   mem_rsp_*                  smem response, echoed {src,tag}, data
//   busy                       stage full or any request outstanding
//   perf_*                     grant / stall counters
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Valid never waits for ready. While a staged
// mem_req_valid is not accepted, the stage contents are held stable.
//
// Optional feature: define TENSOR_SMEM_ARB_PERF_EN to build the perf
// counters. Without it the perf outputs are tied to zero.

module vx_tensor_smem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int TAG_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [TAG_WIDTH-1:0]  a_req_tag,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [TAG_WIDTH-1:0]  a_rsp_tag,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [TAG_WIDTH-1:0]  b_req_tag,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [TAG_WIDTH-1:0]  b_rsp_tag,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TAG_WIDTH:0]    mem_req_tag,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [TAG_WIDTH:0]    mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,

    output logic                  busy,
    output logic [31:0]           perf_a_grants,
    output logic [31:0]           perf_b_grants,
    output logic [31:0]           perf_stall_cycles
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                  r_stage_valid;
    logic [ADDR_WIDTH-1:0] r_stage_addr;
    logic [TAG_WIDTH:0]    r_stage_tag;
    logic [CNT_W-1:0]      r_cnt_a;
    logic [CNT_W-1:0]      r_cnt_b;
    logic                  r_last_b;     // 1: last grant went to B, so A has priority

    logic w_stage_free;
    logic w_elig_a, w_elig_b;
    logic w_grant_a, w_grant_b;
    logic w_rsp_src;
    logic w_rsp_fire_a, w_rsp_fire_b;

    // Eligibility only sees registered counters. A slot freed by a response
    // therefore becomes usable on the following cycle.
    assign w_stage_free = !r_stage_valid || mem_req_ready;
    assign w_elig_a     = a_req_valid && (r_cnt_a < MAX_CNT);
    assign w_elig_b     = b_req_valid && (r_cnt_b < MAX_CNT);
    assign w_grant_a    = w_stage_free && w_elig_a && (!w_elig_b || r_last_b);
    assign w_grant_b    = w_stage_free && w_elig_b && (!w_elig_a || !r_last_b);

    assign a_req_ready  = w_grant_a;
    assign b_req_ready  = w_grant_b;

    assign mem_req_valid = r_stage_valid;
    assign mem_req_addr  = r_stage_addr;
    assign mem_req_tag   = r_stage_tag;

    // Response routing: zero latency, selected by the echoed src bit.
    assign w_rsp_src     = mem_rsp_tag[TAG_WIDTH];
    assign a_rsp_valid   = mem_rsp_valid && !w_rsp_src;
    assign b_rsp_valid   = mem_rsp_valid && w_rsp_src;
    assign a_rsp_tag     = mem_rsp_tag[TAG_WIDTH-1:0];
    assign b_rsp_tag     = mem_rsp_tag[TAG_WIDTH-1:0];
    assign a_rsp_data    = mem_rsp_data;
    assign b_rsp_data    = mem_rsp_data;
    assign mem_rsp_ready = w_rsp_src ? b_rsp_ready : a_rsp_ready;
    assign w_rsp_fire_a  = a_rsp_valid && a_rsp_ready;
    assign w_rsp_fire_b  = b_rsp_valid && b_rsp_ready;

    assign busy = r_stage_valid || (r_cnt_a != '0) || (r_cnt_b != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_last_b      <= 1'b1;
        end else if (w_stage_free) begin
            r_stage_valid <= w_grant_a || w_grant_b;
            if (w_grant_a || w_grant_b) begin
                r_stage_addr <= w_grant_b ? b_req_addr : a_req_addr;
                r_stage_tag  <= {w_grant_b, (w_grant_b ? b_req_tag : a_req_tag)};
                r_last_b     <= w_grant_b;
            end
        end
    end

    // The counters saturate instead of wrapping. A grant together with a
    // response on the same source cancels out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_grant_a && !w_rsp_fire_a && r_cnt_a != MAX_CNT)
                r_cnt_a <= r_cnt_a + CNT_W'(1);
            else if (!w_grant_a && w_rsp_fire_a && r_cnt_a != '0)
                r_cnt_a <= r_cnt_a - CNT_W'(1);
            if (w_grant_b && !w_rsp_fire_b && r_cnt_b != MAX_CNT)
                r_cnt_b <= r_cnt_b + CNT_W'(1);
            else if (!w_grant_b && w_rsp_fire_b && r_cnt_b != '0)
                r_cnt_b <= r_cnt_b - CNT_W'(1);
            a_rsp_underflow: assert (!w_rsp_fire_a || r_cnt_a != '0);
            b_rsp_underflow: assert (!w_rsp_fire_b || r_cnt_b != '0);
        end
    end

`ifdef TENSOR_SMEM_ARB_PERF_EN
    logic [31:0] r_perf_a;
    logic [31:0] r_perf_b;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_a     <= '0;
            r_perf_b     <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_grant_a)
                r_perf_a <= r_perf_a + 32'd1;
            if (w_grant_b)
                r_perf_b <= r_perf_b + 32'd1;
            if ((a_req_valid || b_req_valid) && !(w_grant_a || w_grant_b))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_a_grants     = r_perf_a;
    assign perf_b_grants     = r_perf_b;
    assign perf_stall_cycles = r_perf_stall;
`else
    assign perf_a_grants     = 32'd0;
    assign perf_b_grants     = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_vx_tensor_smem_arbiter.sv
// Bench for vx_tensor_smem_arbiter. It holds a transaction-level model made of
// outstanding counts per source, a priority flag and a queue of staged
// requests. A negedge process compares every DUT output against that model on
// every cycle. Directed sequences add literal expectations at key points.

module tb_vx_tensor_smem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TW = 4;
    localparam int MO = 4;

    logic          clk;
    logic          reset;
    logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [AW-1:0] a_req_addr;
    logic [TW-1:0] a_req_tag, a_rsp_tag;
    logic [DW-1:0] a_rsp_data;
    logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [AW-1:0] b_req_addr;
    logic [TW-1:0] b_req_tag, b_rsp_tag;
    logic [DW-1:0] b_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
    logic [AW-1:0] mem_req_addr;
    logic [TW:0]   mem_req_tag, mem_rsp_tag;
    logic [DW-1:0] mem_rsp_data;
    logic          busy;
    logic [31:0]   perf_a_grants, perf_b_grants, perf_stall_cycles;

    vx_tensor_smem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_req_addr(a_req_addr), .a_req_tag(a_req_tag),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_tag(a_rsp_tag), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_req_addr(b_req_addr), .b_req_tag(b_req_tag),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_tag(b_rsp_tag), .b_rsp_data(b_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .busy(busy),
        .perf_a_grants(perf_a_grants), .perf_b_grants(perf_b_grants),
        .perf_stall_cycles(perf_stall_cycles)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;

    int          m_out_a, m_out_b;      // in-flight count per source
    bit          m_prio_a;              // A wins a tie
    logic [31:0] m_pa, m_pb, m_ps;
    logic [TW+AW:0] exp_q[$];           // staged request {src, tag, addr}
    bit          chk_en = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {grant_b, grant_a} from the arbitration rules and model state.
    function automatic logic [1:0] model_grant();
        bit free, ea, eb, ga, gb;
        free = (exp_q.size() == 0) || mem_req_ready;
        ea   = a_req_valid && (m_out_a < MO);
        eb   = b_req_valid && (m_out_b < MO);
        ga   = free && ea && (!eb || m_prio_a);
        gb   = free && eb && (!ea || !m_prio_a);
        return {gb, ga};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        bit rsp_fire, rsp_src;
        if (reset) begin
            m_out_a = 0; m_out_b = 0; m_prio_a = 1;
            m_pa = 0; m_pb = 0; m_ps = 0;
            exp_q.delete();
            chk_en = 1;
        end else begin
            g = model_grant();
            rsp_src  = mem_rsp_tag[TW];
            rsp_fire = mem_rsp_valid && (rsp_src ? b_rsp_ready : a_rsp_ready);
            if (exp_q.size() != 0 && mem_req_ready) void'(exp_q.pop_front());
            if (g[0]) begin
                exp_q.push_back({1'b0, a_req_tag, a_req_addr});
                m_prio_a = 0; m_out_a++; m_pa++;
            end
            if (g[1]) begin
                exp_q.push_back({1'b1, b_req_tag, b_req_addr});
                m_prio_a = 1; m_out_b++; m_pb++;
            end
            if ((a_req_valid || b_req_valid) && g == 2'b00) m_ps++;
            if (rsp_fire && !rsp_src) m_out_a--;
            if (rsp_fire && rsp_src)  m_out_b--;
        end
    end

    always @(negedge clk) begin
        logic [1:0]     g;
        logic [TW+AW:0] e;
        bit             src;
        if (chk_en) begin
            g = model_grant();
            chk("a_req_ready", a_req_ready, g[0]);
            chk("b_req_ready", b_req_ready, g[1]);
            chk("mem_req_valid", mem_req_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("mem_req_addr", mem_req_addr, e[AW-1:0]);
                chk("mem_req_tag", mem_req_tag, e[TW+AW:AW]);
            end
            chk("busy", busy, (exp_q.size() != 0) || m_out_a != 0 || m_out_b != 0);
            src = mem_rsp_tag[TW];
            chk("a_rsp_valid", a_rsp_valid, mem_rsp_valid && !src);
            chk("b_rsp_valid", b_rsp_valid, mem_rsp_valid && src);
            chk("mem_rsp_ready", mem_rsp_ready, src ? b_rsp_ready : a_rsp_ready);
            if (mem_rsp_valid && !src) begin
                chk("a_rsp_tag", a_rsp_tag, mem_rsp_tag[TW-1:0]);
                chk("a_rsp_data", a_rsp_data, mem_rsp_data);
            end
            if (mem_rsp_valid && src) begin
                chk("b_rsp_tag", b_rsp_tag, mem_rsp_tag[TW-1:0]);
                chk("b_rsp_data", b_rsp_data, mem_rsp_data);
            end
`ifdef TENSOR_SMEM_ARB_PERF_EN
            chk("perf_a", perf_a_grants, m_pa);
            chk("perf_b", perf_b_grants, m_pb);
            chk("perf_stall", perf_stall_cycles, m_ps);
`else
            chk("perf_a_off", perf_a_grants, 0);
            chk("perf_b_off", perf_b_grants, 0);
            chk("perf_stall_off", perf_stall_cycles, 0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        a_req_valid = 0; a_req_addr = '0; a_req_tag = '0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_addr = '0; b_req_tag = '0; b_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_tag = '0; mem_rsp_data = '0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        adv();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- directed sequences ----------------
    initial begin
        logic [DW-1:0] d1, d2;
        int na;
        d1 = {8{32'hA5A5_0001}};
        d2 = {8{32'h5A5A_0002}};
        idle();
        reset = 1;
        adv();
        do_reset();

        // Reset state, then one A request: tag 3, addr 0x100.
        neg();
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_perf_a", perf_a_grants, 0);
        chk("rst_perf_stall", perf_stall_cycles, 0);
        adv();
        a_req_valid = 1; a_req_tag = 4'd3; a_req_addr = 32'h100; mem_req_ready = 1;
        neg();
        chk("s1_a_ready_c0", a_req_ready, 1);
        adv();
        a_req_valid = 0;
        neg();
        chk("s1_mem_valid_c1", mem_req_valid, 1);
        chk("s1_mem_addr_c1", mem_req_addr, 32'h100);
        chk("s1_mem_tag_c1", mem_req_tag, 5'h03);
        chk("s1_model_cnt_a", m_out_a, 1);
        adv();
        mem_rsp_valid = 1; mem_rsp_tag = 5'h03; mem_rsp_data = d1; a_rsp_ready = 1;
        neg();
        chk("s1_a_rsp_valid", a_rsp_valid, 1);
        chk("s1_a_rsp_data", a_rsp_data, d1);
        chk("s1_busy_outstanding", busy, 1);
        adv();
        mem_rsp_valid = 0;
        neg();
        chk("s1_busy_drained", busy, 0);
        adv();

        // Both sources valid: alternate A, B, A, B.
        do_reset();
        a_req_valid = 1; b_req_valid = 1; mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_req_addr = 32'h200 + i; b_req_addr = 32'h300 + i;
            a_req_tag = 4'(i); b_req_tag = 4'(i + 8);
            neg();
            chk("s2_a_ready", a_req_ready, (i % 2) == 0);
            chk("s2_b_ready", b_req_ready, (i % 2) == 1);
            adv();
        end
        a_req_valid = 0; b_req_valid = 0;
        neg();
        chk("s2_model_cnt_a", m_out_a, 2);
        chk("s2_model_cnt_b", m_out_b, 2);
        chk("s2_mem_tag_last", mem_req_tag, 5'h1B);
        adv();

        // Outstanding limit on A, then B still granted.
        do_reset();
        a_req_valid = 1; mem_req_ready = 1; a_req_addr = 32'h40;
        na = 0;
        for (int i = 0; i < 6; i++) begin
            neg();
            if (a_req_ready) na++;
            adv();
        end
        chk("s3_a_grants", na, MO);
        b_req_valid = 1; b_req_addr = 32'h80;
        neg();
        chk("s3_a_blocked", a_req_ready, 0);
        chk("s3_b_granted", b_req_ready, 1);
        adv();
        neg();
        chk("s3_b_granted_over_prio", b_req_ready, 1);
        adv();
        b_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_tag = 5'h00; mem_rsp_data = d2; a_rsp_ready = 1;
        neg();
        chk("s3_free_same_cycle", a_req_ready, 0);
        adv();
        mem_rsp_valid = 0;
        neg();
        chk("s3_free_next_cycle", a_req_ready, 1);
        adv();
        a_req_valid = 0;

        // Stage hold under back-pressure.
        do_reset();
        a_req_valid = 1; a_req_addr = 32'h400; a_req_tag = 4'd5; mem_req_ready = 0;
        neg();
        chk("s4_a_ready_empty", a_req_ready, 1);
        adv();
        a_req_addr = 32'h404; a_req_tag = 4'd6;
        b_req_valid = 1; b_req_addr = 32'h500; b_req_tag = 4'd7;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("s4_hold_a_ready", a_req_ready, 0);
            chk("s4_hold_b_ready", b_req_ready, 0);
            chk("s4_hold_addr", mem_req_addr, 32'h400);
            chk("s4_hold_tag", mem_req_tag, 5'h05);
            adv();
        end
        mem_req_ready = 1;
        neg();
        chk("s4_release_b", b_req_ready, 1);
        chk("s4_release_a", a_req_ready, 0);
        adv();
        a_req_valid = 0; b_req_valid = 0;
        neg();
        chk("s4_next_addr", mem_req_addr, 32'h500);
        chk("s4_next_tag", mem_req_tag, 5'h17);
        adv();

        // Response routing to B, back-pressure, and grant in the same cycle.
        do_reset();
        b_req_valid = 1; b_req_addr = 32'h600; b_req_tag = 4'd2; mem_req_ready = 1;
        adv();
        b_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_tag = 5'h12; mem_rsp_data = d2; b_rsp_ready = 0;
        neg();
        chk("s5_b_rsp_valid", b_rsp_valid, 1);
        chk("s5_a_rsp_valid", a_rsp_valid, 0);
        chk("s5_mem_rsp_ready", mem_rsp_ready, 0);
        chk("s5_b_rsp_tag", b_rsp_tag, 4'd2);
        adv();
        neg();
        chk("s5_model_cnt_b_held", m_out_b, 1);
        adv();
        b_rsp_ready = 1; b_req_valid = 1; b_req_addr = 32'h604; b_req_tag = 4'd3;
        neg();
        chk("s5_mem_rsp_ready_up", mem_rsp_ready, 1);
        chk("s5_b_grant_same", b_req_ready, 1);
        adv();
        b_req_valid = 0; mem_rsp_valid = 0;
        neg();
        chk("s5_model_cnt_b_same", m_out_b, 1);
        chk("s5_busy", busy, 1);
        adv();
        mem_rsp_valid = 1; mem_rsp_tag = 5'h13;
        adv();
        mem_rsp_valid = 0; b_rsp_ready = 0;
        neg();
        chk("s5_busy_drained", busy, 0);
        adv();

        // Perf: 5 A grants, 2 B grants, 3 blocked cycles.
        do_reset();
        a_req_valid = 1; mem_req_ready = 1;
        repeat (4) adv();
        repeat (3) adv();
        a_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_tag = 5'h00; a_rsp_ready = 1;
        adv();
        mem_rsp_valid = 0; a_rsp_ready = 0;
        a_req_valid = 1;
        adv();
        a_req_valid = 0; b_req_valid = 1;
        repeat (2) adv();
        b_req_valid = 0;
        neg();
`ifdef TENSOR_SMEM_ARB_PERF_EN
        chk("s6_perf_a", perf_a_grants, 5);
        chk("s6_perf_b", perf_b_grants, 2);
        chk("s6_perf_stall", perf_stall_cycles, 3);
`else
        chk("s6_perf_a_off", perf_a_grants, 0);
        chk("s6_perf_b_off", perf_b_grants, 0);
        chk("s6_perf_stall_off", perf_stall_cycles, 0);
`endif
        chk("s6_model_pa", m_pa, 5);
        chk("s6_model_ps", m_ps, 3);
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_tensor_smem_arbiter.md
Name: VX_tensor_smem_arbiter

Overview:
- Shares one shared-memory bank port between the tensor core's two operand-fetch request streams, A and B.
- Round-robin arbitration with a per-source outstanding-request limit and a registered request stage.
- Tags each memory request with its source and routes responses back to A or B.
- Sits between the tensor core's reqA/reqB and respA/respB ports and a single smem port, so one bank can feed both operand fetchers.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 256, response data width
- TAG_WIDTH, 4, per-source request tag width
- MAX_OUTSTANDING, 4, maximum in-flight requests per source (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- a_req_valid / a_req_ready  in / out  1 / 1  source A request handshake
- a_req_addr  in  ADDR_WIDTH  source A address
- a_req_tag  in  TAG_WIDTH  source A tag
- a_rsp_valid / a_rsp_ready  out / in  1 / 1  source A response handshake
- a_rsp_tag  out  TAG_WIDTH  returned A tag
- a_rsp_data  out  DATA_WIDTH  returned A data
- b_req_*, b_rsp_*  same widths and directions as the A ports, for source B
- mem_req_valid / mem_req_ready  out / in  1 / 1  smem request handshake
- mem_req_addr  out  ADDR_WIDTH  smem address
- mem_req_tag  out  TAG_WIDTH+1  {src, tag}; src 0=A, 1=B
- mem_rsp_valid / mem_rsp_ready  in / out  1 / 1  smem response handshake
- mem_rsp_tag  in  TAG_WIDTH+1  echoed tag
- mem_rsp_data  in  DATA_WIDTH  response data
- busy  out  1  high when any request is outstanding or the stage is full
- perf_a_grants, perf_b_grants, perf_stall_cycles  out  32 each  perf counters (see Optional Feature)

Behaviour:
- Reset values:
  - mem_req_valid=0; counters cnt_a=cnt_b=0; last_grant=B, so A has priority first.
  - busy=0; perf counters=0.
  - Reset mid-operation discards the stage and clears the counters. The smem side is reset on the same edge, so no stale responses arrive after reset.
- Eligibility: source X is eligible when x_req_valid && cnt_x < MAX_OUTSTANDING.
- Stage accept: stage_free = !mem_req_valid || mem_req_ready.
- Grant (combinational, same cycle as accept):
  - If stage_free and both sources are eligible, grant the source != last_grant.
  - If only one is eligible, grant it.
  - x_req_ready = stage_free && (grant==X). The ready of the non-granted source is 0.
- Grant fire: on the next edge load the stage {addr, {src, tag}}, set mem_req_valid=1, last_grant=src, and cnt_src += 1.
- Request latency: exactly 1 cycle from x_req fire to mem_req_valid. Full throughput is one request per cycle when mem_req_ready is held high.
- Stage hold: when mem_req_valid && !mem_req_ready, the stage holds its contents stable; no grant is issued.
- Response routing is combinational, zero latency:
  - src = mem_rsp_tag[TAG_WIDTH]. The selected x_rsp_valid=mem_rsp_valid; the other source's rsp_valid=0.
  - x_rsp_tag = mem_rsp_tag[TAG_WIDTH-1:0]; x_rsp_data = mem_rsp_data.
  - mem_rsp_ready = selected x_rsp_ready.
- Counter update:
  - cnt_src -= 1 on response fire.
  - Increment and decrement of the same counter in the same cycle leave it unchanged.
  - Counter width is clog2(MAX_OUTSTANDING+1). The counter never wraps.
  - Runtime assert: a response arrives for a source whose counter is 0.
- Boundary cases:
  - cnt_x == MAX_OUTSTANDING blocks X even if it holds priority; the other source is granted.
  - A response freeing a slot in cycle N makes X eligible in cycle N+1, not N.
- busy = mem_req_valid || cnt_a!=0 || cnt_b!=0.
- Ordering: requests from a single source issue in arrival order. Response order is whatever the smem returns; tags disambiguate.

Optional Feature:
- Macro: TENSOR_SMEM_ARB_PERF_EN.
- When defined:
  - perf_a_grants and perf_b_grants increment on each A/B grant fire.
  - perf_stall_cycles increments on every cycle where some x_req_valid=1 but no grant fires.
  - All three are 32-bit, wrap silently, and clear on reset.
- When undefined: all three perf outputs are constant 0 and no counter flops exist.

Test Plan:
- Reset, then A valid alone, tag 3, addr 0x100, mem_req_ready=1 -> a_req_ready=1 in cycle 0; cycle 1 mem_req_valid=1, addr=0x100, tag=0x03; cnt_a=1.
- A and B both valid continuously, mem_req_ready=1 -> grant order A,B,A,B; after the 4th grant, with no responses, both counters are at 2.
- A valid for 6 cycles, no responses, MAX_OUTSTANDING=4 -> exactly 4 A grants. a_req_ready then stays 0, while B is still granted when valid.
- mem_req_ready=0 for 3 cycles with a stage loaded -> mem_req_addr/tag stable, a_req_ready=b_req_ready=0. Release -> the next grant fires in the same cycle.
- mem_rsp tag 0x12 with b_rsp_ready=0 -> b_rsp_valid=1, a_rsp_valid=0, mem_rsp_ready=0, cnt_b unchanged. Raise b_rsp_ready -> cnt_b decrements by 1. A simultaneous B grant leaves cnt_b unchanged.
- With TENSOR_SMEM_ARB_PERF_EN: 5 A grants and 2 B grants with 3 blocked cycles -> perf_a_grants=5, perf_b_grants=2, perf_stall_cycles=3. Undefined -> all three read 0.
